// File: rtl/pe_result_drain.sv
// Result collector behind the systolic PE array: captures each PE's accumulator on
// its result-valid, holds the full tile, then streams it out one row per beat.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_IDLE    | no tile held; waiting for arm
//   ST_COLLECT | capturing first result of each PE until every PE has reported
//   ST_DRAIN   | presenting row row_q on m_*; advancing on each handshake
module pe_result_drain #(
   parameter  int ROWS     = 8,
   parameter  int COLS     = 8,
   parameter  int OUTWIDTH = 32,
   localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          arm,
   input  logic [ROWS*COLS*OUTWIDTH-1:0] outs,
   input  logic [ROWS*COLS-1:0]          outvalids,
   output logic [COLS*OUTWIDTH-1:0]      m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [RW-1:0]                 m_row,
   output logic                          m_last,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun
);

   localparam int            NPE      = ROWS * COLS;
   localparam int            ROW_BITS = COLS * OUTWIDTH;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DRAIN
   } state_t;

   state_t                    state_q, state_d;
   logic [RW-1:0]             row_q, row_d;
   logic [NPE-1:0]            captured_q, captured_d;
   logic [NPE*OUTWIDTH-1:0]   slots_q, slots_d;
   logic                      overrun_q, overrun_d;
   logic                      done_q, done_d;
   logic [ROW_BITS-1:0]       row_words [ROWS];

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      captured_d = captured_q;
      slots_d    = slots_q;
      overrun_d  = overrun_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d    = ST_COLLECT;
               captured_d = '0;
               overrun_d  = 1'b0;
            end
         end
         ST_COLLECT: begin
            // A repeated valid keeps the first value and only flags the error.
            for (int k = 0; k < NPE; k++) begin
               if (outvalids[k]) begin
                  if (!captured_q[k]) begin
                     slots_d[k*OUTWIDTH +: OUTWIDTH] = outs[k*OUTWIDTH +: OUTWIDTH];
                     captured_d[k]                   = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
            if (&captured_d) begin
               state_d = ST_DRAIN;
               row_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (|outvalids) overrun_d = 1'b1;
            if (m_ready) begin
               if (row_q == ROW_LAST) begin
                  state_d = ST_IDLE;
                  row_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            row_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         row_q      <= '0;
         captured_q <= '0;
         slots_q    <= '0;
         overrun_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         captured_q <= captured_d;
         slots_q    <= slots_d;
         overrun_q  <= overrun_d;
         done_q     <= done_d;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_rows
      assign row_words[r] = slots_q[r*ROW_BITS +: ROW_BITS];
   end

   assign m_data  = row_words[row_q];
   assign m_row   = row_q;
   assign m_valid = (state_q == ST_DRAIN);
   assign m_last  = (state_q == ST_DRAIN) && (row_q == ROW_LAST);
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: directed scenarios plus random tiles, every cycle compared
// against a tile/queue-level reference model.
module tb_pe_result_drain;

   localparam int ROWS = 4;
   localparam int COLS = 3;
   localparam int W    = 16;
   localparam int N    = ROWS * COLS;
   localparam int RW   = 2;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 arm = 1'b0;
   logic [N*W-1:0]       outs = '0;
   logic [N-1:0]         outvalids = '0;
   logic [COLS*W-1:0]    m_data;
   logic                 m_valid;
   logic                 m_ready = 1'b0;
   logic [RW-1:0]        m_row;
   logic                 m_last;
   logic                 busy;
   logic                 done;
   logic                 overrun;

   int n_tests = 0;
   int n_fail  = 0;

   pe_result_drain #(.ROWS(ROWS), .COLS(COLS), .OUTWIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .arm(arm), .outs(outs), .outvalids(outvalids),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row),
      .m_last(m_last), .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference model: held values per PE, first-capture flags, and a queue of rows still to emit.
   logic [W-1:0] mslot [N];
   bit           mcap  [N];
   bit           mcollect;
   int           mrows [$];
   bit           movr;
   bit           mdone;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      bit all_in;
      mdone = 1'b0;
      if (!rstn) begin
         mcollect = 1'b0;
         mrows.delete();
         movr = 1'b0;
         for (int k = 0; k < N; k++) begin
            mslot[k] = '0;
            mcap[k]  = 1'b0;
         end
      end else if (mrows.size() > 0) begin
         if (outvalids != '0) movr = 1'b1;
         if (m_ready) begin
            void'(mrows.pop_front());
            if (mrows.size() == 0) mdone = 1'b1;
         end
      end else if (mcollect) begin
         all_in = 1'b1;
         for (int k = 0; k < N; k++) begin
            if (outvalids[k]) begin
               if (mcap[k]) movr = 1'b1;
               else begin
                  mslot[k] = outs[k*W +: W];
                  mcap[k]  = 1'b1;
               end
            end
            if (!mcap[k]) all_in = 1'b0;
         end
         if (all_in) begin
            mcollect = 1'b0;
            for (int r = 0; r < ROWS; r++) mrows.push_back(r);
         end
      end else if (arm) begin
         mcollect = 1'b1;
         movr     = 1'b0;
         for (int k = 0; k < N; k++) mcap[k] = 1'b0;
      end
   endtask

   task automatic compare();
      int              er;
      bit              ev;
      logic [COLS*W-1:0] ed;
      ev = (mrows.size() > 0);
      er = ev ? mrows[0] : 0;
      for (int c = 0; c < COLS; c++) ed[c*W +: W] = mslot[er*COLS + c];
      check("busy",    64'(busy),    64'(mcollect || ev));
      check("m_valid", 64'(m_valid), 64'(ev));
      check("m_row",   64'(m_row),   64'(er));
      check("m_last",  64'(m_last),  64'(ev && (er == ROWS-1)));
      check("m_data",  64'(m_data),  64'(ed));
      check("done",    64'(done),    64'(mdone));
      check("overrun", 64'(overrun), 64'(movr));
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic rand_outs();
      for (int k = 0; k < N; k++) outs[k*W +: W] = W'($urandom);
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   task automatic drain_all(input bit rnd);
      int budget = 300;
      while (mrows.size() > 0 && budget > 0) begin
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cyc();
         budget--;
      end
      if (budget == 0) check("drain_timeout", 64'(mrows.size()), 64'(0));
      m_ready = 1'b0;
      cyc();
   endtask

   task automatic rand_tile();
      int budget = 200;
      arm_pulse();
      while (mcollect && budget > 0) begin
         outvalids = N'($urandom) & N'($urandom);
         rand_outs();
         arm = ($urandom_range(0, 7) == 0);
         cyc();
         budget--;
      end
      if (budget == 0) check("collect_timeout", 64'(mcollect), 64'(0));
      budget = 300;
      while (mrows.size() > 0 && budget > 0) begin
         m_ready   = 1'($urandom_range(0, 1));
         outvalids = ($urandom_range(0, 9) == 0) ? N'(1) << $urandom_range(0, N-1) : '0;
         arm       = ($urandom_range(0, 7) == 0);
         cyc();
         budget--;
      end
      if (budget == 0) check("drain_timeout", 64'(mrows.size()), 64'(0));
      outvalids = '0;
      arm       = 1'b0;
      m_ready   = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with noisy inputs
      rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         arm       = 1'($urandom);
         outvalids = N'($urandom);
         rand_outs();
         cyc();
      end
      rstn = 1'b1; arm = 1'b0; outvalids = '0;
      cyc();

      // Basic tile: one valid per cycle, values 0x100+k, ready held high
      arm_pulse();
      for (int k = 0; k < N; k++) begin
         outvalids = N'(1) << k;
         outs[k*W +: W] = W'(16'h100 + k);
         cyc();
      end
      outvalids = '0;
      drain_all(1'b0);

      // Backpressure: all valids at once, ready low 5 cycles then toggling
      arm_pulse();
      outvalids = '1;
      for (int k = 0; k < N; k++) outs[k*W +: W] = W'(k);
      cyc();
      outvalids = '0;
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      for (int i = 0; i < 4*ROWS && mrows.size() > 0; i++) begin
         m_ready = ~m_ready;
         cyc();
      end
      drain_all(1'b0);

      // Overrun: PE 3 twice during collect, then a valid during drain
      arm_pulse();
      outvalids = N'(1) << 3; outs[3*W +: W] = W'(16'hAA); cyc();
      outvalids = N'(1) << 3; outs[3*W +: W] = W'(16'hBB); cyc();
      outvalids = '1; rand_outs(); outs[3*W +: W] = W'(16'hCC); cyc();
      m_ready = 1'b0; outvalids = N'(1) << 5; cyc();
      outvalids = '0;
      drain_all(1'b1);
      cyc(); cyc();

      // Arm ignored in collect and drain; arm in idle with all valids
      arm_pulse();
      outvalids = N'(12'h00F); rand_outs(); cyc();
      outvalids = '0; arm = 1'b1; cyc();
      arm = 1'b0; outvalids = '1; rand_outs(); cyc();
      outvalids = '0; m_ready = 1'b0; arm = 1'b1; cyc();
      arm = 1'b0;
      drain_all(1'b1);
      arm = 1'b1; outvalids = '1;
      for (int k = 0; k < N; k++) outs[k*W +: W] = W'(5);
      cyc();
      arm = 1'b0; outvalids = '0;
      cyc(); cyc();
      outvalids = '1; rand_outs(); cyc();
      outvalids = '0;
      drain_all(1'b1);

      // Mid-drain reset after row 1 accepted
      arm_pulse();
      outvalids = '1; rand_outs(); cyc();
      outvalids = '0; m_ready = 1'b1;
      cyc(); cyc();
      m_ready = 1'b0; rstn = 1'b0; cyc();
      rstn = 1'b1; cyc(); cyc();
      rand_tile();

      for (int t = 0; t < 20; t++) rand_tile();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Collects the per-PE results of one systolic `PE_ARR` pass and streams them out row by row over a valid/ready interface. It sits directly downstream of the array, on the `outs`/`outvalids` side. It latches each PE's accumulator the cycle that PE asserts its result-valid, holds the full ROWS×COLS tile, then drains it as ROWS beats of COLS words each. It also gives the array controller a `busy` indication so the next `fire` is not issued while a tile is still held.

## Interface
- `ROWS`, default 8, PE array rows, and the number of drain beats.
- `COLS`, default 8, PE array columns, and the words per beat.
- `OUTWIDTH`, default 32, result word width.
- `clk` input, 1 bit, the single clock; all state updates on its rising edge.
- `rstn` input, 1 bit, reset; synchronous, active-low.
- `arm` input, 1 bit, single-cycle pulse that starts a collection. Honoured only in IDLE.
- `outs` input, OUTWIDTH × [ROWS*COLS], PE results, flat index `col + row*COLS`.
- `outvalids` input, 1 × [ROWS*COLS], per-PE result-valid, same indexing as `outs`.
- `m_data` output, OUTWIDTH × [COLS], one row of results; element j is PE `j + m_row*COLS`.
- `m_valid` output, 1 bit, beat valid.
- `m_ready` input, 1 bit, downstream accept.
- `m_row` output, $clog2(ROWS) bits (minimum 1), row index of the current beat.
- `m_last` output, 1 bit, high with `m_valid` on row ROWS-1.
- `busy` output, 1 bit, high in COLLECT and DRAIN.
- `done` output, 1 bit, one-cycle pulse when the tile has been fully drained.
- `overrun` output, 1 bit, sticky error flag; cleared by an accepted `arm`.

## Operation
- **States.** IDLE, COLLECT, DRAIN.
- **IDLE.**
  - `arm`=1 → COLLECT. This clears all ROWS*COLS captured bits and `overrun`.
  - `outvalids` are ignored in IDLE, including in the cycle `arm` is accepted.
- **COLLECT.**
  - For each PE k with `outvalids[k]`=1 and captured[k]=0: store `outs[k]` in slot k and set captured[k].
  - If captured[k] is already 1, the first value is kept and `overrun` is set.
  - When (captured | accepted outvalids) becomes all-ones, go to DRAIN next edge with the row counter at 0.
  - Capturing the final PEs and transitioning happen on the same edge.
- **DRAIN.**
  - `m_valid`=1 and `m_data` = slots of row `m_row`.
  - On `m_valid && m_ready`, the row counter increments.
  - On the handshake with `m_row`=ROWS-1: go to IDLE, pulse `done` for the following cycle, reset the row counter to 0.
  - Any `outvalids[k]`=1 during DRAIN sets `overrun`; the data is discarded.
- **`arm` outside IDLE.** Ignored; no state change.
- **No arithmetic.** Results are passed through bit-exact.
- **Storage.** ROWS*COLS*OUTWIDTH flops, plus ROWS*COLS captured bits.

## Timing
- **Reset values** (rstn=0 at an edge): state IDLE, `m_valid` 0, `m_last` 0, `m_row` 0, `m_data` all 0, `busy` 0, `done` 0, `overrun` 0, captured bits 0, slots 0.
- **Reset mid-operation.** Reset in COLLECT or DRAIN discards the tile immediately; no `done` is produced.
- **Arm latency.** `busy` rises the cycle after `arm` is accepted.
- **Capture latency.** A result presented in cycle t is in its slot from t+1.
- **Drain start.** The first beat (`m_valid`=1, `m_row`=0) appears the cycle after the final capture edge. Minimum latency from the last `outvalids` to the first beat is 1 cycle.
- **Handshake rules.**
  - While `m_valid && !m_ready`, `m_data`, `m_row` and `m_last` are held stable.
  - `m_valid` never drops before acceptance.
- **Throughput.** With `m_ready` tied to 1, ROWS consecutive beats, one per cycle.
- **Last beat.** `m_valid`, `m_last` and `busy` fall on the edge after the last handshake. `done`=1 for exactly that following cycle.
- **Re-arm.** `arm` in the `done` cycle is accepted, since the state is IDLE.
- **Registered outputs.** `m_data` is a mux of the held slots by the registered row counter. All outputs are registered-state-derived; none depend combinationally on `m_ready` or `outvalids`.

## Test plan
- **Reset.** Hold rstn=0 for 3 cycles while driving arbitrary `outvalids`/`arm` → every output at its reset value, `busy`=0.
- **Basic tile (ROWS=COLS=2).**
  - Stimulus: arm; assert valids one per cycle for k=0..3 with outs[k]=0x100+k; `m_ready`=1.
  - Required response: beats {0x100,0x101} row 0, then {0x102,0x103} row 1 with `m_last`; `done` pulses 1 cycle after; `overrun`=0.
- **Backpressure (8×8).**
  - Stimulus: all 64 valids in one cycle with outs[k]=k; `m_ready` low for 5 cycles, then toggling.
  - Required response: row 0 data {0..7} held stable for the 5 cycles; exactly 8 beats total, in row order.
- **Overrun.**
  - Stimulus: in COLLECT, PE 3 valid with 0xAA, then again with 0xBB; also a valid during DRAIN.
  - Required response: slot 3 drains 0xAA; `overrun`=1 persists until the next arm clears it.
- **Ignored arm, and arm in IDLE with valids (2×2).**
  - Stimulus: arm pulsed during COLLECT and DRAIN; then, back in IDLE, arm together with `outvalids`=all-ones (0x5 on all).
  - Required response: the arms during COLLECT and DRAIN have no effect. The arm in IDLE enters COLLECT with captured bits 0, `busy`=1 the next cycle, and no beat emitted.
- **Mid-drain reset.**
  - Stimulus: rstn=0 for 1 cycle after row 1 is accepted.
  - Required response: IDLE, `m_valid`=0, no `done` pulse. A subsequent full tile drains correctly from row 0.
